hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, operand/result width.
REQ-002 The block SHALL provide parameter RADDR_W, default 5, register address width.
REQ-003 The block SHALL provide parameter N_RD, default 2, number of operand read ports.
REQ-004 The block SHALL provide parameter HIST_DEPTH, default 2 (min 1), retired-writeback history entries kept for forwarding.
REQ-005 sysclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 cpu_reset  in  1  reset; synchronous, active-high.
REQ-007 wb_we  in  1  W stage writes the register file this cycle.
REQ-008 wb_addr  in  RADDR_W  W stage destination register.
REQ-009 wb_data  in  DATA_W  W stage result.
REQ-010 wb_retire  in  1  valid (non-bubble) instruction in W this cycle.
REQ-011 wb_halt  in  1  halt opcode (6'b111111) in W this cycle.
REQ-012 ex_raddr  in  N_RD*RADDR_W  EX operand register addresses, port k at bits [k*RADDR_W +: RADDR_W].
REQ-013 ex_rdata_in  in  N_RD*DATA_W  EX operand values latched from the register file.
REQ-014 ex_rdata_out  out  N_RD*DATA_W  forwarded EX operand values.
REQ-015 dec_raddr  in  N_RD*RADDR_W  D stage source registers.
REQ-016 dec_rused  in  N_RD  per-port flag: D stage instruction actually reads that source.
REQ-017 ex_load  in  1  EX instruction is a load.
REQ-018 ex_wreg  in  RADDR_W  EX destination register.
REQ-019 ex_taken  in  1  EX resolved a taken branch/jump.
REQ-020 stall  out  1  hold PC and F/D register; inject bubble into D/E.
REQ-021 flush  out  1  invalidate F and D stage instructions.
REQ-022 halted  out  1  sticky halt indicator.
REQ-023 cycle_cnt  out  DATA_W  cycles elapsed up to and including the halt cycle.
REQ-024 instr_cnt  out  DATA_W  retired instructions.

Function
REQ-025 History SHALL be a HIST_DEPTH-entry shift register of {valid, addr, data}, shifting every cycle; entry 0 loads {wb_we & (wb_addr!=0), wb_addr, wb_data}; the oldest entry is discarded.
REQ-026 For each port k with ex_raddr!=0, ex_rdata_out SHALL take the first match in priority: current W (wb_we, wb_addr) > history entry 0 > ... > entry HIST_DEPTH-1 > ex_rdata_in; with no match, or with address 0, ex_rdata_in passes unchanged.
REQ-027 Forwarding SHALL be combinational (zero latency) from wb_* and ex_* inputs to ex_rdata_out.
REQ-028 stall SHALL be 1, combinationally, when ex_load=1, ex_wreg!=0, and some port k has dec_rused[k]=1 and dec_raddr[k]==ex_wreg; it then drops once the bubble occupies EX (single-cycle interlock).
REQ-029 flush SHALL equal ex_taken combinationally; when flush=1, stall SHALL be 0 (flush wins).
REQ-030 halted SHALL set on the edge after wb_halt=1 and remain set until reset; while halted=1, stall SHALL be 1 and flush 0.
REQ-031 cycle_cnt SHALL increment by 1 every cycle while halted=0, including the wb_halt cycle, and saturate at all-ones.
REQ-032 instr_cnt SHALL increment by 1 each cycle with wb_retire=1 and halted=0, saturating at all-ones; the halt instruction counts.
REQ-033 Simultaneous wb_halt and ex_taken: flush SHALL assert that cycle, halted the next.

Reset
REQ-034 With cpu_reset=1 at an edge, all history entries SHALL become invalid, halted 0, cycle_cnt 0, instr_cnt 0, overriding all other inputs, including mid-halt.
REQ-035 During and after reset, stall and flush SHALL follow only their combinational inputs; with no hazard they SHALL read 0.

Configuration
REQ-036 Macro HAZARD_PERF_EN defined: cycle_cnt and instr_cnt SHALL behave per REQ-031/032.
REQ-037 Macro HAZARD_PERF_EN undefined: counter registers SHALL be omitted and cycle_cnt, instr_cnt tied to 0; all other behaviour unchanged.

Verification
REQ-038 wb_we=1, wb_addr=9, wb_data=55, ex_raddr[0]=9, ex_rdata_in=0 -> ex_rdata_out[0]=55 same cycle; next cycle with wb_we=0 -> still 55 (history 0).
REQ-039 History: write r3=7 then r3=8 on consecutive cycles, then idle, read r3 -> 8; after HIST_DEPTH+1 idle cycles -> ex_rdata_in value.
REQ-040 wb_we=1, wb_addr=0, wb_data=99, ex_raddr=0, ex_rdata_in=0 -> ex_rdata_out=0.
REQ-041 ex_load=1, ex_wreg=4, dec_raddr[1]=4, dec_rused[1]=1 -> stall=1; same with dec_rused[1]=0 -> stall=0; add ex_taken=1 -> flush=1, stall=0.
REQ-042 With HAZARD_PERF_EN: reset, retire 10 instructions over 14 cycles, halt in cycle 14 -> cycle_cnt=14, instr_cnt=10, halted=1, stall=1, counters frozen thereafter; cpu_reset=1 -> all 0.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard unit: W/retired-history operand forwarding, load-use interlock, branch flush,
// sticky halt and optional perf counters (enabled by defining HAZARD_PERF_EN).

module hazard_fwd_port #(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter int HIST_DEPTH = 2
) (
    input  logic [RADDR_W-1:0]                 ex_raddr,
    input  logic [DATA_W-1:0]                  ex_rdata_in,
    input  logic [RADDR_W-1:0]                 dec_raddr,
    input  logic                               dec_rused,
    input  logic [RADDR_W-1:0]                 ex_wreg,
    input  logic                               wb_we,
    input  logic [RADDR_W-1:0]                 wb_addr,
    input  logic [DATA_W-1:0]                  wb_data,
    input  logic [HIST_DEPTH-1:0]              hist_vld,
    input  logic [HIST_DEPTH-1:0][RADDR_W-1:0] hist_addr,
    input  logic [HIST_DEPTH-1:0][DATA_W-1:0]  hist_data,
    output logic [DATA_W-1:0]                  ex_rdata_out,
    output logic                               luse_match
);
    // Walk from the oldest entry to the newest so that younger writes override older ones.
    always_comb begin
        ex_rdata_out = ex_rdata_in;
        if (ex_raddr != '0) begin
            for (int i = HIST_DEPTH - 1; i >= 0; i--)
                if (hist_vld[i] && hist_addr[i] == ex_raddr) ex_rdata_out = hist_data[i];
            if (wb_we && wb_addr == ex_raddr) ex_rdata_out = wb_data;
        end
    end

    assign luse_match = dec_rused && (dec_raddr == ex_wreg);
endmodule

module hazard_unit #(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter int N_RD       = 2,
    parameter int HIST_DEPTH = 2
) (
    input  logic                    sysclk,
    input  logic                    cpu_reset,
    input  logic                    wb_we,
    input  logic [RADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    wb_retire,
    input  logic                    wb_halt,
    input  logic [N_RD*RADDR_W-1:0] ex_raddr,
    input  logic [N_RD*DATA_W-1:0]  ex_rdata_in,
    output logic [N_RD*DATA_W-1:0]  ex_rdata_out,
    input  logic [N_RD*RADDR_W-1:0] dec_raddr,
    input  logic [N_RD-1:0]         dec_rused,
    input  logic                    ex_load,
    input  logic [RADDR_W-1:0]      ex_wreg,
    input  logic                    ex_taken,
    output logic                    stall,
    output logic                    flush,
    output logic                    halted,
    output logic [DATA_W-1:0]       cycle_cnt,
    output logic [DATA_W-1:0]       instr_cnt
);
    typedef struct packed {
        logic               vld;
        logic [RADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } hist_t;

    hist_t [HIST_DEPTH-1:0]              hist;
    logic  [HIST_DEPTH-1:0]              hist_vld;
    logic  [HIST_DEPTH-1:0][RADDR_W-1:0] hist_addr;
    logic  [HIST_DEPTH-1:0][DATA_W-1:0]  hist_data;
    logic  [N_RD-1:0]                    port_luse;
    logic                                load_use;

    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            hist <= '0;
        end else begin
            hist[0] <= '{vld: wb_we && (wb_addr != '0), addr: wb_addr, data: wb_data};
            for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    for (genvar i = 0; i < HIST_DEPTH; i++) begin : g_hist
        assign hist_vld[i]  = hist[i].vld;
        assign hist_addr[i] = hist[i].addr;
        assign hist_data[i] = hist[i].data;
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_port
        hazard_fwd_port #(
            .DATA_W    (DATA_W),
            .RADDR_W   (RADDR_W),
            .HIST_DEPTH(HIST_DEPTH)
        ) u_port (
            .ex_raddr    (ex_raddr[k*RADDR_W +: RADDR_W]),
            .ex_rdata_in (ex_rdata_in[k*DATA_W +: DATA_W]),
            .dec_raddr   (dec_raddr[k*RADDR_W +: RADDR_W]),
            .dec_rused   (dec_rused[k]),
            .ex_wreg     (ex_wreg),
            .wb_we       (wb_we),
            .wb_addr     (wb_addr),
            .wb_data     (wb_data),
            .hist_vld    (hist_vld),
            .hist_addr   (hist_addr),
            .hist_data   (hist_data),
            .ex_rdata_out(ex_rdata_out[k*DATA_W +: DATA_W]),
            .luse_match  (port_luse[k])
        );
    end

    // Halt freezes the front end; otherwise a taken branch outranks a load-use bubble.
    assign load_use = ex_load && (ex_wreg != '0) && (|port_luse);
    assign flush    = !halted && ex_taken;
    assign stall    = halted || (!ex_taken && load_use);

    always_ff @(posedge sysclk) begin
        if (cpu_reset)    halted <= 1'b0;
        else if (wb_halt) halted <= 1'b1;
    end

`ifdef HAZARD_PERF_EN
    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (!halted) begin
            if (cycle_cnt != '1)              cycle_cnt <= cycle_cnt + CNT_ONE;
            if (wb_retire && instr_cnt != '1) instr_cnt <= instr_cnt + CNT_ONE;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = wb_retire;
    assign cycle_cnt     = '0;
    assign instr_cnt     = '0;
`endif
endmodule
